// File: rtl/u_mul_pkg.sv
// Shared types and widths for the multiplier / product-accumulator datapath.
package u_mul_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam int MUL_IN_W      = 8;
    localparam int MUL_PROD_W    = 16;
    localparam int DEFAULT_ACC_W = 24;

endpackage

// File: rtl/u_acc_adder.sv
// Accumulator adder: acc + zero-extended product at ACC_W+1 bits, returns next sum and carry.
// U_PRODUCT_ACCUMULATOR_SATURATE_EN clamps the sum to all-ones on carry instead of wrapping.
module u_acc_adder #(
    parameter int PROD_W = 16,
    parameter int ACC_W  = 24
) (
    input  logic [ACC_W-1:0]  acc_i,
    input  logic [PROD_W-1:0] prod_i,
    output logic [ACC_W-1:0]  sum_o,
    output logic              carry_o
);

    logic [ACC_W:0] wide;

    assign wide    = {1'b0, acc_i} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod_i};
    assign carry_o = wide[ACC_W];

`ifdef U_PRODUCT_ACCUMULATOR_SATURATE_EN
    // Once clamped, any further nonzero product carries again, so the sum stays pinned.
    assign sum_o = carry_o ? {ACC_W{1'b1}} : wide[ACC_W-1:0];
`else
    assign sum_o = wide[ACC_W-1:0];
`endif

endmodule

// File: rtl/u_product_accumulator.sv
// Sums frames of COUNT products into an ACC_W-bit result with valid/ready on both sides.
// Optional build macro: U_PRODUCT_ACCUMULATOR_SATURATE_EN (saturate instead of wrap).
module u_product_accumulator
    import u_mul_pkg::*;
#(
    parameter int PROD_W = MUL_PROD_W,
    parameter int ACC_W  = DEFAULT_ACC_W,
    parameter int COUNT  = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [PROD_W-1:0] prod,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ACC_W-1:0]  sum,
    output logic              sum_valid,
    input  logic              sum_ready,
    output logic              overflow,
    output logic              busy
);

    localparam logic [7:0] LAST_IDX = 8'(COUNT - 1);

    state_e            state_q;
    logic [ACC_W-1:0]  sum_q;
    logic              ovf_q;
    logic [7:0]        cnt_q;
    logic              sum_valid_q;
    logic              busy_q;

    logic [ACC_W-1:0]  add_sum;
    logic              add_carry;

    u_acc_adder #(
        .PROD_W (PROD_W),
        .ACC_W  (ACC_W)
    ) u_adder (
        .acc_i   (sum_q),
        .prod_i  (prod),
        .sum_o   (add_sum),
        .carry_o (add_carry)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            sum_q       <= '0;
            ovf_q       <= 1'b0;
            cnt_q       <= 8'd0;
            sum_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= ACCUM;
                        sum_q   <= '0;
                        ovf_q   <= 1'b0;
                        cnt_q   <= 8'd0;
                        busy_q  <= 1'b1;
                    end
                end
                ACCUM: begin
                    if (in_valid) begin
                        sum_q <= add_sum;
                        cnt_q <= cnt_q + 8'd1;
                        if (add_carry) ovf_q <= 1'b1;
                        if (cnt_q == LAST_IDX) begin
                            state_q     <= DONE;
                            sum_valid_q <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (sum_ready) begin
                        sum_valid_q <= 1'b0;
                        // start with the handshake chains straight into the next frame
                        if (start) begin
                            state_q <= ACCUM;
                            sum_q   <= '0;
                            ovf_q   <= 1'b0;
                            cnt_q   <= 8'd0;
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    sum_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = (state_q == ACCUM);
    assign sum       = sum_q;
    assign sum_valid = sum_valid_q;
    assign overflow  = ovf_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_u_product_accumulator.sv
// Self-checking bench: three instances (24b/COUNT=4, 16b/COUNT=2, 24b/COUNT=1) on shared stimulus.
module tb_u_product_accumulator;

    typedef struct packed {
        logic [23:0] sum;
        logic        ovf;
    } exp_t;

    logic        clock;
    logic        reset;
    logic        start;
    logic [15:0] prod;
    logic        in_valid;
    logic        sum_ready;

    logic        a_in_ready, a_sum_valid, a_overflow, a_busy;
    logic [23:0] a_sum;
    logic        o_in_ready, o_sum_valid, o_overflow, o_busy;
    logic [15:0] o_sum;
    logic        s_in_ready, s_sum_valid, s_overflow, s_busy;
    logic [23:0] s_sum;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    u_product_accumulator #(.PROD_W(16), .ACC_W(24), .COUNT(4)) dut (
        .clock(clock), .reset(reset), .start(start), .prod(prod), .in_valid(in_valid),
        .in_ready(a_in_ready), .sum(a_sum), .sum_valid(a_sum_valid), .sum_ready(sum_ready),
        .overflow(a_overflow), .busy(a_busy)
    );

    u_product_accumulator #(.PROD_W(16), .ACC_W(16), .COUNT(2)) dut_o (
        .clock(clock), .reset(reset), .start(start), .prod(prod), .in_valid(in_valid),
        .in_ready(o_in_ready), .sum(o_sum), .sum_valid(o_sum_valid), .sum_ready(sum_ready),
        .overflow(o_overflow), .busy(o_busy)
    );

    u_product_accumulator #(.PROD_W(16), .ACC_W(24), .COUNT(1)) dut_1 (
        .clock(clock), .reset(reset), .start(start), .prod(prod), .in_valid(in_valid),
        .in_ready(s_in_ready), .sum(s_sum), .sum_valid(s_sum_valid), .sum_ready(sum_ready),
        .overflow(s_overflow), .busy(s_busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Scoreboard: pop on every completed output handshake of the main instance.
    always @(negedge clock) begin
        if (reset && a_sum_valid && sum_ready) begin
            exp_t e;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got sum=%h with no expected frame", a_sum);
            end else begin
                e = exp_q.pop_front();
                if (a_sum !== e.sum || a_overflow !== e.ovf) begin
                    errors++;
                    $display("FAIL sb_frame: got sum=%h ovf=%b, expected sum=%h ovf=%b",
                             a_sum, a_overflow, e.sum, e.ovf);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0; start = 1'b0; in_valid = 1'b0; prod = '0; sum_ready = 1'b0;
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic begin_frame();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic xfer(input logic [15:0] p);
        in_valid = 1'b1;
        prod     = p;
        tick();
        in_valid = 1'b0;
        prod     = 16'hFFFF;
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; in_valid = 1'b0; prod = '0; sum_ready = 1'b0;
        #2;
        checks++;
        if ({a_sum, a_sum_valid, a_in_ready, a_overflow, a_busy} !== 28'd0) begin
            errors++;
            $display("FAIL reset_main: got sum=%h sv=%b ir=%b ov=%b busy=%b, expected all 0",
                     a_sum, a_sum_valid, a_in_ready, a_overflow, a_busy);
        end
        checks++;
        if ({o_sum, o_sum_valid, o_in_ready, o_overflow, o_busy,
             s_sum, s_sum_valid, s_in_ready, s_overflow, s_busy} !== 48'd0) begin
            errors++;
            $display("FAIL reset_other: got o_sum=%h s_sum=%h flags=%b%b%b%b %b%b%b%b, expected all 0",
                     o_sum, s_sum, o_sum_valid, o_in_ready, o_overflow, o_busy,
                     s_sum_valid, s_in_ready, s_overflow, s_busy);
        end
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        do_reset();
        sum_ready = 1'b1;
        begin_frame();
        checks++;
        if (a_in_ready !== 1'b1 || a_busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_accum_entry: got in_ready=%b busy=%b, expected 1 1", a_in_ready, a_busy);
        end
        exp_q.push_back('{sum: 24'h03F804, ovf: 1'b0});
        for (int i = 0; i < 3; i++) xfer(16'hFE01);
        checks++;
        if (a_sum_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_early_valid: got sum_valid=%b, expected 0", a_sum_valid);
        end
        xfer(16'hFE01);
        checks++;
        if (a_sum_valid !== 1'b1 || a_in_ready !== 1'b0) begin
            errors++;
            $display("FAIL basic_latency: got sum_valid=%b in_ready=%b, expected 1 0", a_sum_valid, a_in_ready);
        end
        tick();
        checks++;
        if (a_sum_valid !== 1'b0 || a_busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_to_idle: got sum_valid=%b busy=%b, expected 0 0", a_sum_valid, a_busy);
        end
        sum_ready = 1'b0;
    endtask

    task automatic test_gaps_backpressure();
        logic [15:0] prods [4];
        logic [23:0] held;
        prods[0] = 16'h0E10; prods[1] = 16'h3872; prods[2] = 16'h0E10; prods[3] = 16'h0001;
        do_reset();
        sum_ready = 1'b0;
        begin_frame();
        exp_q.push_back('{sum: 24'h005493, ovf: 1'b0});
        for (int i = 0; i < 4; i++) begin
            xfer(prods[i]);
            if (i < 3) begin
                held = a_sum;
                tick();
                tick();
                checks++;
                if (a_sum !== held || a_sum_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL gap_hold_%0d: got sum=%h sv=%b, expected sum=%h sv=0", i, a_sum, a_sum_valid, held);
                end
            end
        end
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (a_sum !== 24'h005493 || a_in_ready !== 1'b0 || a_sum_valid !== 1'b1) begin
                errors++;
                $display("FAIL bp_hold_%0d: got sum=%h ir=%b sv=%b, expected 005493 0 1",
                         c, a_sum, a_in_ready, a_sum_valid);
            end
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
        end
        sum_ready = 1'b1;
        tick();
        sum_ready = 1'b0;
    endtask

    task automatic test_overflow();
        logic [15:0] exp_sum;
`ifdef U_PRODUCT_ACCUMULATOR_SATURATE_EN
        exp_sum = 16'hFFFF;
`else
        exp_sum = 16'hFC02;
`endif
        do_reset();
        sum_ready = 1'b0;
        begin_frame();
        xfer(16'hFE01);
        xfer(16'hFE01);
        checks++;
        if (o_sum_valid !== 1'b1 || o_sum !== exp_sum || o_overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_frame: got sv=%b sum=%h ovf=%b, expected 1 %h 1", o_sum_valid, o_sum, o_overflow, exp_sum);
        end
        sum_ready = 1'b1;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        sum_ready = 1'b0;
        checks++;
        if (o_overflow !== 1'b0 || o_sum !== 16'h0000 || o_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL ovf_clear: got ovf=%b sum=%h ir=%b, expected 0 0000 1", o_overflow, o_sum, o_in_ready);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        sum_ready = 1'b0;
        begin_frame();
        exp_q.push_back('{sum: 24'h000008, ovf: 1'b0});
        for (int i = 0; i < 4; i++) xfer(16'h0002);
        sum_ready = 1'b1;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        checks++;
        if (a_sum !== 24'd0 || a_in_ready !== 1'b1 || a_sum_valid !== 1'b0 || a_busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_restart: got sum=%h ir=%b sv=%b busy=%b, expected 0 1 0 1",
                     a_sum, a_in_ready, a_sum_valid, a_busy);
        end
        exp_q.push_back('{sum: 24'h000004, ovf: 1'b0});
        for (int i = 0; i < 4; i++) xfer(16'h0001);
        checks++;
        if (a_sum_valid !== 1'b1 || a_sum !== 24'h000004) begin
            errors++;
            $display("FAIL b2b_second: got sv=%b sum=%h, expected 1 000004", a_sum_valid, a_sum);
        end
        tick();
        sum_ready = 1'b0;
    endtask

    task automatic test_reset_midframe();
        do_reset();
        begin_frame();
        xfer(16'h0010);
        xfer(16'h0010);
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({a_sum, a_sum_valid, a_in_ready, a_overflow, a_busy} !== 28'd0) begin
            errors++;
            $display("FAIL midreset_async: got sum=%h sv=%b ir=%b ov=%b busy=%b, expected all 0",
                     a_sum, a_sum_valid, a_in_ready, a_overflow, a_busy);
        end
        #1;
        reset = 1'b1;
        tick();
        sum_ready = 1'b1;
        begin_frame();
        exp_q.push_back('{sum: 24'h000040, ovf: 1'b0});
        for (int i = 0; i < 4; i++) xfer(16'h0010);
        tick();
        sum_ready = 1'b0;
    endtask

    task automatic test_count_one();
        do_reset();
        begin_frame();
        xfer(16'h1234);
        checks++;
        if (s_sum_valid !== 1'b1 || s_sum !== 24'h001234 || s_in_ready !== 1'b0 || s_busy !== 1'b1) begin
            errors++;
            $display("FAIL count_one: got sv=%b sum=%h ir=%b busy=%b, expected 1 001234 0 1",
                     s_sum_valid, s_sum, s_in_ready, s_busy);
        end
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; in_valid = 1'b0; prod = '0; sum_ready = 1'b0;
        test_reset();
        test_basic();
        test_gaps_backpressure();
        test_overflow();
        test_back_to_back();
        test_reset_midframe();
        test_count_one();
        tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d frames outstanding, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
